// File: rtl/tile_irq_pkg.sv
// Shared definitions for the tile interrupt agent: register map, FSM states, VECTOR/STATUS fields.
package tile_irq_pkg;

  localparam int REG_ENABLE  = 0;
  localparam int REG_CHMAP   = 1;
  localparam int REG_PENDING = 2;
  localparam int REG_VECTOR  = 3;
  localparam int REG_STATUS  = 4;
  localparam int REG_NMI     = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACKED   = 2'd2,
    RELEASE = 2'd3
  } irq_state_e;

  localparam int VEC_SRC_W     = 8;
  localparam int VEC_CH_BIT    = 8;
  localparam int VEC_VALID_BIT = 31;
  localparam int STAT_SPUR_BIT = 8;

endpackage

// File: rtl/tile_irq_agent_if.sv
// Local CPU/MCU register bus into tile_irq_agent; read data is registered and returns the cycle after the strobe.
interface tile_irq_agent_if #(parameter int AW = 4);
  logic          reg_wr_en;
  logic          reg_rd_en;
  logic [AW-1:0] reg_addr;
  logic [31:0]   reg_wdata;
  logic [31:0]   reg_rdata;

  modport master (output reg_wr_en, reg_rd_en, reg_addr, reg_wdata, input reg_rdata);
  modport slave  (input reg_wr_en, reg_rd_en, reg_addr, reg_wdata, output reg_rdata);
endinterface

// File: rtl/tile_irq_prio_enc.sv
// Lowest-index set-bit finder; purely combinational, returns found flag and 8-bit index.
module tile_irq_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] vec_i,
  output logic         found_o,
  output logic [7:0]   idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        found_o = 1'b1;
        idx_o   = 8'(i);
      end
    end
  end

endmodule

// File: rtl/tile_irq_agent.sv
// Tile-side Dock interrupt agent: serialises two maskable INT channels through one ack/EOI handshake.
// Optional NMI path is built only when TILE_IRQ_NMI_EN is defined.
module tile_irq_agent
  import tile_irq_pkg::*;
#(
  parameter int NUM_SRC         = 8,
  parameter int NUM_TILE_INT_CH = 2,
  parameter int GAP_CYCLES      = 4,
  parameter int REG_ADDR_WIDTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         src_irq,
`ifdef TILE_IRQ_NMI_EN
  input  logic                       nmi_src,
`endif
  output logic [NUM_TILE_INT_CH-1:0] tile_int_req,
  output logic                       tile_nmi_req,
  input  logic                       slot_ack,
  tile_irq_agent_if.slave            reg_bus,
  output logic                       irq_pending_any
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int AW = REG_ADDR_WIDTH;

  logic [NUM_SRC-1:0] src_q, en_q, en_d, map_q, map_d, pend_q, pend_d;
  logic [NUM_SRC-1:0] ep0_q, ep1_q, ep0_d, ep1_d, live_sh;
  logic               wr_en_sel, wr_map_sel, wr_pend_sel, wr_stat_sel;
  logic               spur_q;
  logic [31:0]        rdata_q, rd_val, nmi_rd;
  irq_state_e         state_q;
  logic [1:0]         req_q;
  logic               ch_q;
  logic [GW-1:0]      gap_q;
  logic               vec_vld_q, vec_ch_q;
  logic [7:0]         vec_src_q;
  logic               f0, f1, cur_found, nxt_nonempty, hold_ok;
  logic [7:0]         i0, i1, cur_idx;
  logic               unused_wdata;

  assign wr_en_sel   = reg_bus.reg_wr_en && (reg_bus.reg_addr == AW'(REG_ENABLE));
  assign wr_map_sel  = reg_bus.reg_wr_en && (reg_bus.reg_addr == AW'(REG_CHMAP));
  assign wr_pend_sel = reg_bus.reg_wr_en && (reg_bus.reg_addr == AW'(REG_PENDING));
  assign wr_stat_sel = reg_bus.reg_wr_en && (reg_bus.reg_addr == AW'(REG_STATUS));
  assign unused_wdata = ^reg_bus.reg_wdata;

  // A fresh edge on a source outranks a simultaneous W1C of the same bit.
  assign en_d   = wr_en_sel  ? reg_bus.reg_wdata[NUM_SRC-1:0] : en_q;
  assign map_d  = wr_map_sel ? reg_bus.reg_wdata[NUM_SRC-1:0] : map_q;
  assign pend_d = (pend_q & ~(wr_pend_sel ? reg_bus.reg_wdata[NUM_SRC-1:0] : '0))
                | (src_irq & ~src_q);

  assign ep0_q = pend_q & en_q & ~map_q;
  assign ep1_q = pend_q & en_q & map_q;
  assign ep0_d = pend_d & en_d & ~map_d;
  assign ep1_d = pend_d & en_d & map_d;

  tile_irq_prio_enc #(.N(NUM_SRC)) u_enc0 (.vec_i(ep0_q), .found_o(f0), .idx_o(i0));
  tile_irq_prio_enc #(.N(NUM_SRC)) u_enc1 (.vec_i(ep1_q), .found_o(f1), .idx_o(i1));

  assign cur_found    = ch_q ? f1 : f0;
  assign cur_idx      = ch_q ? i1 : i0;
  assign nxt_nonempty = ch_q ? |ep1_d : |ep0_d;
  assign live_sh      = (pend_d & en_d) >> vec_src_q;
  assign hold_ok      = live_sh[0];

  // Ack is judged against start-of-cycle pending; emptiness and EOI against next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      ch_q      <= 1'b0;
      gap_q     <= '0;
      vec_vld_q <= 1'b0;
      vec_ch_q  <= 1'b0;
      vec_src_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (f0) begin
            req_q <= 2'b01; ch_q <= 1'b0; state_q <= REQ;
          end else if (f1) begin
            req_q <= 2'b10; ch_q <= 1'b1; state_q <= REQ;
          end
        end
        REQ: begin
          if (slot_ack && cur_found) begin
            vec_vld_q <= 1'b1; vec_ch_q <= ch_q; vec_src_q <= cur_idx; state_q <= ACKED;
          end else if (!nxt_nonempty) begin
            req_q <= '0; gap_q <= GW'(GAP_CYCLES); state_q <= RELEASE;
          end
        end
        ACKED: begin
          if (!hold_ok) begin
            req_q <= '0; vec_vld_q <= 1'b0; gap_q <= GW'(GAP_CYCLES); state_q <= RELEASE;
          end
        end
        RELEASE: begin
          if (gap_q <= GW'(1)) begin
            gap_q <= '0; state_q <= IDLE;
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end
      endcase
    end
  end

`ifdef TILE_IRQ_NMI_EN
  logic nmi_src_q, nmi_pend_q, nmi_en_q, nmi_req_q, nmi_pend_d, nmi_en_d, wr_nmi_sel;
  assign wr_nmi_sel = reg_bus.reg_wr_en && (reg_bus.reg_addr == AW'(REG_NMI));
  assign nmi_pend_d = (nmi_pend_q & ~(wr_nmi_sel & reg_bus.reg_wdata[0])) | (nmi_src & ~nmi_src_q);
  assign nmi_en_d   = wr_nmi_sel ? reg_bus.reg_wdata[1] : nmi_en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_src_q <= 1'b0; nmi_pend_q <= 1'b0; nmi_en_q <= 1'b0; nmi_req_q <= 1'b0;
    end else begin
      nmi_src_q  <= nmi_src;
      nmi_pend_q <= nmi_pend_d;
      nmi_en_q   <= nmi_en_d;
      nmi_req_q  <= nmi_pend_d & nmi_en_d;
    end
  end
  assign tile_nmi_req = nmi_req_q;
  assign nmi_rd       = {30'd0, nmi_en_q, nmi_pend_q};
`else
  assign tile_nmi_req = 1'b0;
  assign nmi_rd       = '0;
`endif

  always_comb begin
    rd_val = '0;
    case (reg_bus.reg_addr)
      AW'(REG_ENABLE):  rd_val = 32'(en_q);
      AW'(REG_CHMAP):   rd_val = 32'(map_q);
      AW'(REG_PENDING): rd_val = 32'(pend_q);
      AW'(REG_VECTOR): begin
        rd_val[VEC_VALID_BIT]   = vec_vld_q;
        rd_val[VEC_CH_BIT]      = vec_ch_q;
        rd_val[VEC_SRC_W-1:0]   = vec_src_q;
      end
      AW'(REG_STATUS): begin
        rd_val[1:0]           = state_q;
        rd_val[STAT_SPUR_BIT] = spur_q;
      end
      AW'(REG_NMI):     rd_val = nmi_rd;
      default:          rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q   <= '0;
      en_q    <= '0;
      map_q   <= '0;
      pend_q  <= '0;
      spur_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      src_q   <= src_irq;
      en_q    <= en_d;
      map_q   <= map_d;
      pend_q  <= pend_d;
      spur_q  <= (spur_q & ~(wr_stat_sel & reg_bus.reg_wdata[STAT_SPUR_BIT]))
               | (slot_ack & (state_q != REQ));
      rdata_q <= reg_bus.reg_rd_en ? rd_val : '0;
    end
  end

  assign tile_int_req      = req_q;
  assign reg_bus.reg_rdata = rdata_q;
  assign irq_pending_any   = |(pend_q & en_q);

endmodule

// File: tb/tb_tile_irq_agent.sv
// Directed scenarios plus randomized traffic, checked every cycle against a behavioural model of the agent.
module tb_tile_irq_agent;

  localparam int NS  = 8;
  localparam int GAP = 4;
  localparam int P_IDLE = 0, P_REQ = 1, P_ACKED = 2, P_REL = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NS-1:0] src_irq = '0;
  logic          slot_ack = 1'b0;
  logic [1:0]    tile_int_req;
  logic          tile_nmi_req;
  logic          irq_pending_any;
`ifdef TILE_IRQ_NMI_EN
  logic          nmi_src = 1'b0;
`endif

  tile_irq_agent_if #(.AW(4)) bus ();

  tile_irq_agent #(.NUM_SRC(NS), .NUM_TILE_INT_CH(2), .GAP_CYCLES(GAP), .REG_ADDR_WIDTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .src_irq(src_irq),
`ifdef TILE_IRQ_NMI_EN
    .nmi_src(nmi_src),
`endif
    .tile_int_req(tile_int_req),
    .tile_nmi_req(tile_nmi_req),
    .slot_ack(slot_ack),
    .reg_bus(bus),
    .irq_pending_any(irq_pending_any)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [NS-1:0] m_pend, m_en, m_map, m_prev;
  int            m_phase, m_ch, m_gap, m_vsrc;
  logic          m_vvalid, m_vch, m_spur;
  logic [31:0]   m_rdata;
  logic          m_nmi_prev, m_nmi_pend, m_nmi_en, m_nmi_req;
  logic [NS-1:0] t_npend, t_nen, t_nmap, t_live_now, t_live_nxt;
  logic          t_wr, t_nnpend, t_nnen;
  int            t_old_phase;

  function automatic int lowest(input logic [NS-1:0] v);
    for (int i = 0; i < NS; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a)
      4'h0: return 32'(m_en);
      4'h1: return 32'(m_map);
      4'h2: return 32'(m_pend);
      4'h3: return {m_vvalid, 22'd0, m_vch, 8'(m_vsrc)};
      4'h4: return {23'd0, m_spur, 6'd0, 2'(m_phase)};
      4'h5: return {30'd0, m_nmi_en, m_nmi_pend};
      default: return 32'd0;
    endcase
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_pend = '0; m_en = '0; m_map = '0; m_prev = '0;
      m_phase = P_IDLE; m_ch = 0; m_gap = 0; m_vsrc = 0;
      m_vvalid = 0; m_vch = 0; m_spur = 0; m_rdata = '0;
      m_nmi_prev = 0; m_nmi_pend = 0; m_nmi_en = 0; m_nmi_req = 0;
    end else begin
      t_wr    = bus.reg_wr_en;
      t_nen   = (t_wr && bus.reg_addr == 4'h0) ? bus.reg_wdata[NS-1:0] : m_en;
      t_nmap  = (t_wr && bus.reg_addr == 4'h1) ? bus.reg_wdata[NS-1:0] : m_map;
      t_npend = (m_pend & ~((t_wr && bus.reg_addr == 4'h2) ? bus.reg_wdata[NS-1:0] : '0))
              | (src_irq & ~m_prev);
      m_rdata = bus.reg_rd_en ? model_read(bus.reg_addr) : 32'd0;
      t_live_now = m_pend & m_en & (m_ch ? m_map : ~m_map);
      t_live_nxt = t_npend & t_nen & (m_ch ? t_nmap : ~t_nmap);
      t_old_phase = m_phase;
      case (m_phase)
        P_IDLE: begin
          if ((m_pend & m_en & ~m_map) != 0) begin m_phase = P_REQ; m_ch = 0; end
          else if ((m_pend & m_en & m_map) != 0) begin m_phase = P_REQ; m_ch = 1; end
        end
        P_REQ: begin
          if (slot_ack && t_live_now != 0) begin
            m_vvalid = 1; m_vch = m_ch[0]; m_vsrc = lowest(t_live_now); m_phase = P_ACKED;
          end else if (t_live_nxt == 0) begin
            m_phase = P_REL; m_gap = GAP;
          end
        end
        P_ACKED: begin
          if (!(t_npend[m_vsrc] && t_nen[m_vsrc])) begin
            m_vvalid = 0; m_phase = P_REL; m_gap = GAP;
          end
        end
        default: begin
          m_gap--;
          if (m_gap == 0) m_phase = P_IDLE;
        end
      endcase
      m_spur = (m_spur && !(t_wr && bus.reg_addr == 4'h4 && bus.reg_wdata[8]))
             || (slot_ack && t_old_phase != P_REQ);
`ifdef TILE_IRQ_NMI_EN
      t_nnpend = (m_nmi_pend && !(t_wr && bus.reg_addr == 4'h5 && bus.reg_wdata[0]))
               || (nmi_src && !m_nmi_prev);
      t_nnen   = (t_wr && bus.reg_addr == 4'h5) ? bus.reg_wdata[1] : m_nmi_en;
      m_nmi_pend = t_nnpend; m_nmi_en = t_nnen; m_nmi_req = t_nnpend & t_nnen;
      m_nmi_prev = nmi_src;
`endif
      m_pend = t_npend; m_en = t_nen; m_map = t_nmap; m_prev = src_irq;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      check("int_req", 32'(tile_int_req),
            32'((m_phase == P_REQ || m_phase == P_ACKED) ? (m_ch ? 2'b10 : 2'b01) : 2'b00));
      check("pending_any", 32'(irq_pending_any), 32'(|(m_pend & m_en)));
      check("rdata", bus.reg_rdata, m_rdata);
      check("nmi_req", 32'(tile_nmi_req), 32'(m_nmi_req));
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] v;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.reg_wr_en = 1'b1; bus.reg_addr = a; bus.reg_wdata = d;
    @(negedge clk);
    bus.reg_wr_en = 1'b0; bus.reg_wdata = '0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    bus.reg_rd_en = 1'b1; bus.reg_addr = a;
    @(negedge clk);
    bus.reg_rd_en = 1'b0;
    d = bus.reg_rdata;
  endtask

  task automatic ack_pulse();
    slot_ack = 1'b1;
    @(negedge clk);
    slot_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.reg_wr_en = 1'b0; bus.reg_rd_en = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;
    tick(3);
    rst_n = 1'b1;
    check("reset req", 32'(tile_int_req), 32'd0);
    for (int a = 0; a < 6; a++) begin
      rd(4'(a), v);
      check("reset reg", v, 32'd0);
    end

    // Test 1: single source on channel 0 through ack, EOI and gap
    wr(4'h0, 32'h01); wr(4'h1, 32'h00);
    src_irq[0] = 1'b1;
    tick(1);
    check("t1 req early", 32'(tile_int_req), 32'd0);
    check("t1 pend any", 32'(irq_pending_any), 32'd1);
    tick(1);
    check("t1 req", 32'(tile_int_req), 32'h1);
    rd(4'h2, v); check("t1 pending", v, 32'h1);
    ack_pulse();
    rd(4'h3, v); check("t1 vector", v, 32'h8000_0000);
    rd(4'h4, v); check("t1 status acked", v, 32'h2);
    wr(4'h2, 32'h01);
    check("t1 req dropped", 32'(tile_int_req), 32'd0);
    rd(4'h4, v); check("t1 status release", v, 32'h3);
    tick(6);
    rd(4'h4, v); check("t1 status idle", v, 32'h0);
    src_irq = '0;

    // Test 2: two channels pending together, channel 0 served first
    wr(4'h0, 32'h06); wr(4'h1, 32'h04);
    src_irq[2:1] = 2'b11;
    tick(2);
    check("t2 req ch0", 32'(tile_int_req), 32'h1);
    ack_pulse();
    rd(4'h3, v); check("t2 vector ch0", v, 32'h8000_0001);
    wr(4'h2, 32'h02);
    check("t2 gap", 32'(tile_int_req), 32'd0);
    tick(6);
    check("t2 req ch1", 32'(tile_int_req), 32'h2);
    ack_pulse();
    rd(4'h3, v); check("t2 vector ch1", v, 32'h8000_0102);
    wr(4'h2, 32'h04);
    tick(8);
    src_irq = '0;

    // Test 3: W1C before ack, then a spurious ack in IDLE
    wr(4'h0, 32'h08); wr(4'h1, 32'h00);
    src_irq[3] = 1'b1;
    tick(2);
    check("t3 req", 32'(tile_int_req), 32'h1);
    rd(4'h4, v); check("t3 status req", v, 32'h1);
    wr(4'h2, 32'h08);
    check("t3 req dropped", 32'(tile_int_req), 32'd0);
    rd(4'h3, v); check("t3 vector valid", 32'(v[31]), 32'd0);
    tick(6);
    ack_pulse();
    rd(4'h4, v); check("t3 spur", v, 32'h100);
    wr(4'h4, 32'h100);
    rd(4'h4, v); check("t3 spur cleared", v, 32'h0);
    src_irq = '0;

    // Test 4: EOI collides with a new edge of the serviced source
    wr(4'h0, 32'h20);
    src_irq[5] = 1'b1;
    tick(1);
    src_irq[5] = 1'b0;
    tick(1);
    check("t4 req", 32'(tile_int_req), 32'h1);
    ack_pulse();
    rd(4'h4, v); check("t4 acked", v, 32'h2);
    src_irq[5] = 1'b1;
    wr(4'h2, 32'h20);
    check("t4 req held", 32'(tile_int_req), 32'h1);
    rd(4'h2, v); check("t4 pending kept", v, 32'h20);
    rd(4'h4, v); check("t4 still acked", v, 32'h2);

    // Test 5: asynchronous reset while ACKED
    #2;
    rst_n = 1'b0;
    #1;
    check("t5 async drop", 32'(tile_int_req), 32'd0);
    src_irq = '0;
    tick(2);
    rst_n = 1'b1;
    for (int a = 0; a < 6; a++) begin
      rd(4'(a), v);
      check("t5 reg cleared", v, 32'd0);
    end

`ifdef TILE_IRQ_NMI_EN
    // Test 6: NMI alongside an INT request
    wr(4'h5, 32'h2); wr(4'h0, 32'h01);
    src_irq[0] = 1'b1;
    nmi_src = 1'b1;
    tick(2);
    check("t6 nmi", 32'(tile_nmi_req), 32'd1);
    check("t6 int", 32'(tile_int_req), 32'h1);
    wr(4'h5, 32'h1);
    check("t6 nmi cleared", 32'(tile_nmi_req), 32'd0);
    nmi_src = 1'b0;
    src_irq = '0;
    wr(4'h2, 32'hFF);
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 11) == 0) src_irq = src_irq ^ (NS'(1) << $urandom_range(0, NS - 1));
`ifdef TILE_IRQ_NMI_EN
      if ($urandom_range(0, 15) == 0) nmi_src = ~nmi_src;
`endif
      slot_ack      = ($urandom_range(0, 6) == 0);
      bus.reg_wr_en = ($urandom_range(0, 7) == 0);
      bus.reg_rd_en = ($urandom_range(0, 2) == 0);
      bus.reg_addr  = 4'($urandom_range(0, 7));
      bus.reg_wdata = $urandom;
      @(negedge clk);
    end
    slot_ack = 1'b0; bus.reg_wr_en = 1'b0; bus.reg_rd_en = 1'b0;
    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
